repeat_seq_checker: RTL and testbench
=====================================

# repeat_seq_checker

Receiving-end checker for the repeat-N counting stream produced by our repeat-count generators, such as the 0,1,2 sequence with each value held 5 cycles. It samples the count bus and aligns to symbol boundaries. After a number of correct symbols it declares lock, then tracks the stream with an internal model and flags every deviation. It sits on the consumer side of the counter, as a monitor or as a sync-qualifier for downstream logic.

## Interface
- `WIDTH`, 2: width of count bus.
- `HOLD`, 5: cycles each value is held (≥2).
- `LAST`, 2: final value before wrap to 0 (≤ 2^WIDTH−1).
- `LOCK_N`, 2: consecutive good symbols required to lock.
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `en` in 1: sample qualifier. When low, all state is frozen and no checks run.
- `cnt_in` in WIDTH: observed count value.
- `locked` out 1: checker is in LOCK.
- `err` out 1: one-cycle error pulse.
- `err_count` out 8: number of errors, saturating at 255.
- `sym_done` out 1: pulse on the last sample of a correct symbol (LOCK only).
- `wrap` out 1: pulse with `sym_done` when the symbol value is `LAST`.

## Operation
- States: HUNT, SYNC, LOCK. Reset enters HUNT.
- `next(v)` = 0 if v==`LAST`, else v+1.
- Internal registers: `prev_val` (WIDTH), `run_len` (saturates at HOLD+1), `good_cnt` (saturates at LOCK_N), `phase` (1..HOLD).
- **HUNT**
  - First enabled sample loads `prev_val`.
  - On a change (`cnt_in`≠`prev_val`), go to SYNC with `run_len`=1, `prev_val`=`cnt_in`, `good_cnt`=0.
  - No errors are raised in HUNT.
- **SYNC, same value:**
  - `run_len`++.
  - If `run_len` would exceed HOLD: `err` fires once, `good_cnt`=0, and `run_len` saturates with no repeat flag until the next change.
- **SYNC, change:**
  - The symbol is good if `run_len`==HOLD and `cnt_in`==`next(prev_val)`. Good: `good_cnt`++. Bad: `err`, `good_cnt`=0.
  - Then `run_len`=1, `prev_val`=`cnt_in`.
  - If `good_cnt` reaches LOCK_N, go to LOCK with `phase`=1.
- **LOCK**
  - Expected value = `prev_val` if `phase`<HOLD, else `next(prev_val)`.
  - Match: advance the model. If `phase`==HOLD, set `prev_val`=`next(prev_val)` and `phase`=1; otherwise `phase`++.
  - When the updated `phase` equals HOLD (the last sample of the symbol), pulse `sym_done`, plus `wrap` if `prev_val`==`LAST`.
  - Mismatch: `err`, go to HUNT and load `prev_val`=`cnt_in`.
- **Out-of-range** (`cnt_in`>`LAST`) in SYNC or LOCK: `err`, go to HUNT.
- **`err_count`:** increments on every `err` pulse and saturates at 255. Only reset clears it.
- **`en` low:** no state or counter change, and `err`/`sym_done`/`wrap` stay low.

## Timing
- All outputs are registered. A response to the sample taken at edge k is visible after edge k, i.e. for one cycle only in the case of pulses.
- Reset values: `locked`=0, `err`=0, `err_count`=0, `sym_done`=0, `wrap`=0, state HUNT.
- Reset asserted mid-LOCK takes effect at the next edge with all of the values above.
- Lock latency from a clean stream starting at value 0 with the checker reset together with the generator:
  - Change seen at sample HOLD.
  - Then LOCK_N further changes.
  - `locked` rises after sample (LOCK_N+1)·HOLD. With defaults, that is sample 15 (samples numbered from 0).
- Error latency: same edge as the offending sample. Re-lock needs a full HUNT→SYNC→LOCK sequence.
- Simultaneous error and lock-qualifying change cannot occur: a bad symbol resets `good_cnt`.

## Test plan
- **Clean stream:** reset, `en`=1, drive 0×5,1×5,2×5 repeating. Required: `locked`=1 after sample 15, `err` never fires, `sym_done` every 5 cycles, `wrap` every 15 cycles (2-symbol ends).
- **Overlong hold:** after lock, hold 1 for 6 cycles. Required: `err` on the 6th sample, `err_count`=1, `locked`=0. Re-lock occurs after 3 further changes.
- **Skipped value:** in SYNC, drive 0×5 then 2. Required: `err`, `good_cnt` cleared. Lock is delayed by one symbol set.
- **Out-of-range:** after lock, drive value 3 for one cycle. Required: `err`, state HUNT, `err_count` increments.
- **Enable gaps:** insert `en`=0 for 7 cycles mid-symbol while `cnt_in` changes arbitrarily. Required: no `err`, `locked` stays 1, `phase` resumes correctly.
- **Reset and saturation:**
  - Assert `rst_n`=0 mid-LOCK: all outputs read 0 at the next edge.
  - Inject 300 errors: `err_count` holds at 255.

Source files
------------

// File: rtl/repeat_seq_checker_if.sv
// Bus bundle between a repeat-count generator (master) and the
// repeat_seq_checker monitor (slave). Clock and reset are not part of
// the bundle.
interface repeat_seq_checker_if #(
  parameter int WIDTH = 2
);
  logic             en;
  logic [WIDTH-1:0] cnt_in;
  logic             locked;
  logic             err;
  logic [7:0]       err_count;
  logic             sym_done;
  logic             wrap;

  // Generator side: drives the samples and observes checker status.
  modport master (
    output en,
    output cnt_in,
    input  locked,
    input  err,
    input  err_count,
    input  sym_done,
    input  wrap
  );

  // Checker side: consumes the samples and reports status.
  modport slave (
    input  en,
    input  cnt_in,
    output locked,
    output err,
    output err_count,
    output sym_done,
    output wrap
  );
endinterface

// File: rtl/repeat_seq_checker.sv
// Receiving-end checker for a repeat-N counting stream (0,1,..,LAST with
// each value held HOLD cycles). It hunts for a value change, verifies
// LOCK_N consecutive well-formed symbols, then tracks the stream with an
// internal phase model and flags every deviation.
module repeat_seq_checker #(
  parameter int WIDTH  = 2,
  parameter int HOLD   = 5,
  parameter int LAST   = 2,
  parameter int LOCK_N = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  repeat_seq_checker_if.slave  bus
);

  localparam int RW = $clog2(HOLD + 2);
  localparam int PW = $clog2(HOLD + 1);
  localparam int GW = $clog2(LOCK_N + 1);

  localparam logic [RW-1:0]    RUN_ONE   = RW'(1);
  localparam logic [RW-1:0]    RUN_HOLD  = RW'(HOLD);
  localparam logic [RW-1:0]    RUN_SAT   = RW'(HOLD + 1);
  localparam logic [PW-1:0]    PH_ONE    = PW'(1);
  localparam logic [PW-1:0]    PH_HOLD   = PW'(HOLD);
  localparam logic [GW-1:0]    GOOD_ONE  = GW'(1);
  localparam logic [GW-1:0]    GOOD_LOCK = GW'(LOCK_N);
  localparam logic [WIDTH-1:0] LAST_V    = WIDTH'(LAST);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    SYNC = 2'd1,
    LOCK = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_prev_val;
  logic             r_have_prev;
  logic [RW-1:0]    r_run_len;
  logic [GW-1:0]    r_good_cnt;
  logic [PW-1:0]    r_phase;
  logic             r_locked;
  logic             r_err;
  logic [7:0]       r_err_count;
  logic             r_sym_done;
  logic             r_wrap;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_prev_nxt;
  logic             w_have_nxt;
  logic [RW-1:0]    w_run_nxt;
  logic [GW-1:0]    w_good_nxt;
  logic [PW-1:0]    w_phase_nxt;
  logic             w_err_nxt;
  logic             w_sym_nxt;
  logic             w_wrap_nxt;
  logic [7:0]       w_err_count_nxt;
  logic [WIDTH-1:0] w_succ;
  logic [WIDTH-1:0] w_expected;
  logic [GW-1:0]    w_good_inc;
  logic             w_out_of_range;

  function automatic logic [WIDTH-1:0] nextVal(input logic [WIDTH-1:0] v);
    return (v == LAST_V) ? '0 : v + WIDTH'(1);
  endfunction

  assign w_succ         = nextVal(r_prev_val);
  assign w_expected     = (r_phase < PH_HOLD) ? r_prev_val : w_succ;
  assign w_good_inc     = r_good_cnt + GOOD_ONE;
  assign w_out_of_range = (bus.cnt_in > LAST_V);

  // Next-state and next-register computation for the hunt/sync/lock FSM;
  // everything holds and pulses stay low while the sample qualifier is low.
  always_comb begin
    w_state_nxt = r_state;
    w_prev_nxt  = r_prev_val;
    w_have_nxt  = r_have_prev;
    w_run_nxt   = r_run_len;
    w_good_nxt  = r_good_cnt;
    w_phase_nxt = r_phase;
    w_err_nxt   = 1'b0;
    w_sym_nxt   = 1'b0;
    w_wrap_nxt  = 1'b0;
    if (bus.en) begin
      case (r_state)
        HUNT: begin
          if (!r_have_prev) begin
            w_prev_nxt = bus.cnt_in;
            w_have_nxt = 1'b1;
          end else if (bus.cnt_in != r_prev_val) begin
            w_state_nxt = SYNC;
            w_run_nxt   = RUN_ONE;
            w_prev_nxt  = bus.cnt_in;
            w_good_nxt  = '0;
          end
        end
        SYNC: begin
          if (w_out_of_range) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = HUNT;
            w_prev_nxt  = bus.cnt_in;
            w_have_nxt  = 1'b1;
          end else if (bus.cnt_in == r_prev_val) begin
            if (r_run_len == RUN_HOLD) begin
              w_err_nxt  = 1'b1;
              w_good_nxt = '0;
              w_run_nxt  = RUN_SAT;
            end else if (r_run_len != RUN_SAT) begin
              w_run_nxt = r_run_len + RUN_ONE;
            end
          end else begin
            if ((r_run_len == RUN_HOLD) && (bus.cnt_in == w_succ)) begin
              w_good_nxt = w_good_inc;
              if (w_good_inc >= GOOD_LOCK) begin
                w_good_nxt  = GOOD_LOCK;
                w_state_nxt = LOCK;
                w_phase_nxt = PH_ONE;
              end
            end else begin
              w_err_nxt  = 1'b1;
              w_good_nxt = '0;
            end
            w_run_nxt  = RUN_ONE;
            w_prev_nxt = bus.cnt_in;
          end
        end
        LOCK: begin
          if (w_out_of_range || (bus.cnt_in != w_expected)) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = HUNT;
            w_prev_nxt  = bus.cnt_in;
            w_have_nxt  = 1'b1;
          end else begin
            if (r_phase == PH_HOLD) begin
              w_prev_nxt  = w_succ;
              w_phase_nxt = PH_ONE;
            end else begin
              w_phase_nxt = r_phase + PH_ONE;
            end
            if (w_phase_nxt == PH_HOLD) begin
              w_sym_nxt  = 1'b1;
              w_wrap_nxt = (w_prev_nxt == LAST_V);
            end
          end
        end
        default: begin
          w_state_nxt = HUNT;
          w_have_nxt  = 1'b0;
        end
      endcase
    end
  end

  // Saturating error counter advance, driven by the same decision as err.
  always_comb begin
    w_err_count_nxt = r_err_count;
    if (w_err_nxt && (r_err_count != 8'hFF)) begin
      w_err_count_nxt = r_err_count + 8'd1;
    end
  end

  // State and status registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= HUNT;
      r_prev_val  <= '0;
      r_have_prev <= 1'b0;
      r_run_len   <= '0;
      r_good_cnt  <= '0;
      r_phase     <= PH_ONE;
      r_locked    <= 1'b0;
      r_err       <= 1'b0;
      r_err_count <= 8'd0;
      r_sym_done  <= 1'b0;
      r_wrap      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_prev_val  <= w_prev_nxt;
      r_have_prev <= w_have_nxt;
      r_run_len   <= w_run_nxt;
      r_good_cnt  <= w_good_nxt;
      r_phase     <= w_phase_nxt;
      r_locked    <= (w_state_nxt == LOCK);
      r_err       <= w_err_nxt;
      r_err_count <= w_err_count_nxt;
      r_sym_done  <= w_sym_nxt;
      r_wrap      <= w_wrap_nxt;
    end
  end

  assign bus.locked    = r_locked;
  assign bus.err       = r_err;
  assign bus.err_count = r_err_count;
  assign bus.sym_done  = r_sym_done;
  assign bus.wrap      = r_wrap;

endmodule

// File: tb/tb_repeat_seq_checker.sv
// Directed self-checking bench for repeat_seq_checker with default
// parameters (WIDTH=2, HOLD=5, LAST=2, LOCK_N=2).
module tb_repeat_seq_checker;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   pos = 0;

  repeat_seq_checker_if #(.WIDTH(2)) bus ();

  repeat_seq_checker #(
    .WIDTH(2), .HOLD(5), .LAST(2), .LOCK_N(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Value of a clean 0x5,1x5,2x5 stream at sample n.
  function automatic logic [1:0] streamVal(input int n);
    return 2'((n / 5) % 3);
  endfunction

  // Present one sample, clock it in, and settle just after the edge.
  task automatic applyStimulus(input logic e, input logic [1:0] v);
    bus.en     = e;
    bus.cnt_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset;
    rst_n = 1'b0;
    applyStimulus(1'b1, 2'd0);
    applyStimulus(1'b1, 2'd0);
    rst_n = 1'b1;
    pos   = 0;
  endtask

  // Clean stream samples 0..15; locked is high after sample 15.
  task automatic lockUp;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, streamVal(pos));
      pos++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    applyStimulus(1'b0, 2'd0);
    applyStimulus(1'b1, 2'd1);
    checks++;
    if (bus.locked !== 1'b0) begin errors++; $display("[TB] FAIL reset_locked: got %0b expected 0", bus.locked); end
    checks++;
    if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %0b expected 0", bus.err); end
    checks++;
    if (bus.err_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_err_count: got %0d expected 0", bus.err_count); end
    checks++;
    if (bus.sym_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_sym_done: got %0b expected 0", bus.sym_done); end
    checks++;
    if (bus.wrap !== 1'b0) begin errors++; $display("[TB] FAIL reset_wrap: got %0b expected 0", bus.wrap); end
    rst_n = 1'b1;
  endtask

  task automatic test_clean_stream;
    logic expLocked, expSym, expWrap;
    doReset();
    for (int n = 0; n < 45; n++) begin
      applyStimulus(1'b1, streamVal(n));
      expLocked = (n >= 15);
      expSym    = (n >= 19) && (n % 5 == 4);
      expWrap   = (n >= 29) && (n % 15 == 14);
      checks++;
      if (bus.locked !== expLocked) begin errors++; $display("[TB] FAIL clean_locked s%0d: got %0b expected %0b", n, bus.locked, expLocked); end
      checks++;
      if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL clean_err s%0d: got %0b expected 0", n, bus.err); end
      checks++;
      if (bus.sym_done !== expSym) begin errors++; $display("[TB] FAIL clean_sym_done s%0d: got %0b expected %0b", n, bus.sym_done, expSym); end
      checks++;
      if (bus.wrap !== expWrap) begin errors++; $display("[TB] FAIL clean_wrap s%0d: got %0b expected %0b", n, bus.wrap, expWrap); end
    end
    checks++;
    if (bus.err_count !== 8'd0) begin errors++; $display("[TB] FAIL clean_err_count: got %0d expected 0", bus.err_count); end
  endtask

  task automatic test_overlong_hold;
    int errSeen;
    doReset();
    lockUp();
    checks++;
    if (bus.locked !== 1'b1) begin errors++; $display("[TB] FAIL overlong_prelock: got %0b expected 1", bus.locked); end
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, streamVal(pos));
      pos++;
    end
    checks++;
    if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL overlong_fifth: got %0b expected 0", bus.err); end
    applyStimulus(1'b1, 2'd1);
    checks++;
    if (bus.err !== 1'b1) begin errors++; $display("[TB] FAIL overlong_err: got %0b expected 1", bus.err); end
    checks++;
    if (bus.err_count !== 8'd1) begin errors++; $display("[TB] FAIL overlong_err_count: got %0d expected 1", bus.err_count); end
    checks++;
    if (bus.locked !== 1'b0) begin errors++; $display("[TB] FAIL overlong_unlock: got %0b expected 0", bus.locked); end
    errSeen = 0;
    while (pos < 35) begin
      applyStimulus(1'b1, streamVal(pos));
      pos++;
      if (bus.err === 1'b1) errSeen++;
    end
    checks++;
    if (bus.locked !== 1'b0) begin errors++; $display("[TB] FAIL relock_early: got %0b expected 0", bus.locked); end
    applyStimulus(1'b1, streamVal(pos));
    pos++;
    checks++;
    if (bus.locked !== 1'b1) begin errors++; $display("[TB] FAIL relock: got %0b expected 1", bus.locked); end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, streamVal(pos));
      pos++;
      if (bus.err === 1'b1) errSeen++;
    end
    checks++;
    if (bus.sym_done !== 1'b1) begin errors++; $display("[TB] FAIL relock_sym_done: got %0b expected 1", bus.sym_done); end
    checks++;
    if (errSeen !== 0) begin errors++; $display("[TB] FAIL relock_no_err: got %0d pulses expected 0", errSeen); end
  endtask

  // Continues from the locked state left by test_overlong_hold (pos 40).
  task automatic test_reset_mid_lock;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, streamVal(pos));
      pos++;
    end
    rst_n = 1'b0;
    applyStimulus(1'b1, streamVal(pos));
    checks++;
    if (bus.locked !== 1'b0) begin errors++; $display("[TB] FAIL midrst_locked: got %0b expected 0", bus.locked); end
    checks++;
    if (bus.err_count !== 8'd0) begin errors++; $display("[TB] FAIL midrst_err_count: got %0d expected 0", bus.err_count); end
    checks++;
    if (bus.sym_done !== 1'b0) begin errors++; $display("[TB] FAIL midrst_sym_done: got %0b expected 0", bus.sym_done); end
    checks++;
    if (bus.wrap !== 1'b0) begin errors++; $display("[TB] FAIL midrst_wrap: got %0b expected 0", bus.wrap); end
    checks++;
    if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL midrst_err: got %0b expected 0", bus.err); end
    rst_n = 1'b1;
  endtask

  task automatic test_skipped_value;
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'd2);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 2'd0);
    applyStimulus(1'b1, 2'd2);
    checks++;
    if (bus.err !== 1'b1) begin errors++; $display("[TB] FAIL skip_err: got %0b expected 1", bus.err); end
    checks++;
    if (bus.err_count !== 8'd1) begin errors++; $display("[TB] FAIL skip_err_count: got %0d expected 1", bus.err_count); end
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'd2);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 2'd0);
    checks++;
    if (bus.locked !== 1'b0) begin errors++; $display("[TB] FAIL skip_lock_early: got %0b expected 0", bus.locked); end
    applyStimulus(1'b1, 2'd1);
    checks++;
    if (bus.locked !== 1'b1) begin errors++; $display("[TB] FAIL skip_lock: got %0b expected 1", bus.locked); end
    checks++;
    if (bus.err_count !== 8'd1) begin errors++; $display("[TB] FAIL skip_final_count: got %0d expected 1", bus.err_count); end
  endtask

  task automatic test_sync_overlong;
    doReset();
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 2'd2);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 2'd0);
    checks++;
    if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL sync_hold_ok: got %0b expected 0", bus.err); end
    applyStimulus(1'b1, 2'd0);
    checks++;
    if (bus.err !== 1'b1) begin errors++; $display("[TB] FAIL sync_overlong_err: got %0b expected 1", bus.err); end
    applyStimulus(1'b1, 2'd0);
    applyStimulus(1'b1, 2'd0);
    checks++;
    if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL sync_overlong_once: got %0b expected 0", bus.err); end
    checks++;
    if (bus.err_count !== 8'd1) begin errors++; $display("[TB] FAIL sync_overlong_count: got %0d expected 1", bus.err_count); end
  endtask

  task automatic test_out_of_range;
    doReset();
    lockUp();
    applyStimulus(1'b1, 2'd3);
    checks++;
    if (bus.err !== 1'b1) begin errors++; $display("[TB] FAIL oor_err: got %0b expected 1", bus.err); end
    checks++;
    if (bus.locked !== 1'b0) begin errors++; $display("[TB] FAIL oor_locked: got %0b expected 0", bus.locked); end
    checks++;
    if (bus.err_count !== 8'd1) begin errors++; $display("[TB] FAIL oor_err_count: got %0d expected 1", bus.err_count); end
    applyStimulus(1'b1, streamVal(pos));
    checks++;
    if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL oor_hunt_quiet: got %0b expected 0", bus.err); end
    checks++;
    if (bus.locked !== 1'b0) begin errors++; $display("[TB] FAIL oor_hunt_locked: got %0b expected 0", bus.locked); end
  endtask

  task automatic test_enable_gaps;
    logic [1:0] junk [7];
    logic       expSym;
    junk = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd3, 2'd2, 2'd1};
    doReset();
    lockUp();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, streamVal(pos));
      pos++;
    end
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, junk[i]);
      checks++;
      if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL gap_err c%0d: got %0b expected 0", i, bus.err); end
      checks++;
      if (bus.locked !== 1'b1) begin errors++; $display("[TB] FAIL gap_locked c%0d: got %0b expected 1", i, bus.locked); end
      checks++;
      if (bus.sym_done !== 1'b0) begin errors++; $display("[TB] FAIL gap_sym_done c%0d: got %0b expected 0", i, bus.sym_done); end
    end
    while (pos < 25) begin
      applyStimulus(1'b1, streamVal(pos));
      expSym = (pos % 5 == 4);
      checks++;
      if (bus.sym_done !== expSym) begin errors++; $display("[TB] FAIL gap_resume_sym s%0d: got %0b expected %0b", pos, bus.sym_done, expSym); end
      checks++;
      if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL gap_resume_err s%0d: got %0b expected 0", pos, bus.err); end
      pos++;
    end
    checks++;
    if (bus.err_count !== 8'd0) begin errors++; $display("[TB] FAIL gap_err_count: got %0d expected 0", bus.err_count); end
  endtask

  task automatic test_saturation;
    int errSeen;
    doReset();
    applyStimulus(1'b1, 2'd0);
    applyStimulus(1'b1, 2'd1);
    errSeen = 0;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, (i % 2 == 0) ? 2'd0 : 2'd1);
      if (bus.err === 1'b1) errSeen++;
      if (i == 253) begin
        checks++;
        if (bus.err_count !== 8'd254) begin errors++; $display("[TB] FAIL sat_254: got %0d expected 254", bus.err_count); end
      end
      if (i == 254) begin
        checks++;
        if (bus.err_count !== 8'd255) begin errors++; $display("[TB] FAIL sat_255: got %0d expected 255", bus.err_count); end
      end
    end
    checks++;
    if (errSeen !== 300) begin errors++; $display("[TB] FAIL sat_pulses: got %0d expected 300", errSeen); end
    checks++;
    if (bus.err_count !== 8'd255) begin errors++; $display("[TB] FAIL sat_hold: got %0d expected 255", bus.err_count); end
  endtask

  // Scenario sequence and summary.
  initial begin
    rst_n      = 1'b0;
    bus.en     = 1'b0;
    bus.cnt_in = 2'd0;
    test_reset();
    test_clean_stream();
    test_overlong_hold();
    test_reset_mid_lock();
    test_skipped_value();
    test_sync_overlong();
    test_out_of_range();
    test_enable_gaps();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
